// File: rtl/mdu.sv
// Multiply/divide unit owning HI/LO: multi-cycle MULT/MULTU/DIV/DIVU plus single-edge MTHI/MTLO.
// Latency MULT_CYCLES/DIV_CYCLES edges from launch to HI/LO update; requests arriving while busy are dropped, never queued.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic [2:0]  op,
    input  logic        start,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   rhi, rlo;
    logic          rwr;
    logic          launch, commit, is_div;
    logic [31:0]   calc_hi, calc_lo;
    logic [63:0]   prod_s, prod_u;
    logic [31:0]   quot_s, rem_s;

    assign is_div = (op == OP_DIV) || (op == OP_DIVU);

    // Sign-extend to 64 bits so the low 64 bits of the product are exact.
    assign prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign prod_u = {32'd0, A} * {32'd0, B};

    always_comb begin
        quot_s = 32'd0;
        rem_s  = 32'd0;
        if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
            quot_s = 32'h8000_0000;
            rem_s  = 32'd0;
        end else if (B != 32'd0) begin
            quot_s = $signed(A) / $signed(B);
            rem_s  = $signed(A) % $signed(B);
        end
    end

    always_comb begin
        calc_hi = 32'd0;
        calc_lo = 32'd0;
        case (op)
            OP_MULT:  {calc_hi, calc_lo} = prod_s;
            OP_MULTU: {calc_hi, calc_lo} = prod_u;
            OP_DIV: begin
                calc_hi = rem_s;
                calc_lo = quot_s;
            end
            OP_DIVU: begin
                if (B != 32'd0) begin
                    calc_hi = A % B;
                    calc_lo = A / B;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        launch    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (start && op >= OP_MULT && op <= OP_DIVU) begin
                    launch    = 1'b1;
                    state_nxt = RUN;
                    cnt_nxt   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                end
            end
            RUN: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    commit    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            busy  <= (cnt_nxt != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rhi <= 32'd0;
            rlo <= 32'd0;
            rwr <= 1'b0;
            hi  <= 32'd0;
            lo  <= 32'd0;
        end else begin
            if (launch) begin
                rhi <= calc_hi;
                rlo <= calc_lo;
                // Divide by zero burns the full busy period but leaves HI/LO alone.
                rwr <= !(is_div && B == 32'd0);
            end
            if (commit && rwr) begin
                hi <= rhi;
                lo <= rlo;
            end
            if (state == IDLE && op == OP_MTHI) hi <= A;
            if (state == IDLE && op == OP_MTLO) lo <= A;
        end
    end
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: reset, multiply/divide results and latency, MTHI/MTLO, ignored requests, mid-run reset.
module tb_mdu;
    logic        clk;
    logic        reset;
    logic [31:0] A, B;
    logic [2:0]  op;
    logic        start;
    logic        busy;
    logic [31:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk(clk), .reset(reset), .A(A), .B(B), .op(op), .start(start),
        .busy(busy), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Launch one operation at the next edge and count how many post-edge samples show busy.
    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          output int cycles, output logic [31:0] mid_hi, output logic [31:0] mid_lo);
        @(negedge clk);
        op = o; A = a; B = b; start = 1'b1;
        @(posedge clk); #1;
        op = 3'd0; start = 1'b0;
        cycles = 0; mid_hi = 32'hx; mid_lo = 32'hx;
        while (busy && cycles < 50) begin
            cycles++;
            if (cycles == 2) begin
                mid_hi = hi;
                mid_lo = lo;
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        reset = 1'b0; A = 32'd0; B = 32'd0; op = 3'd0; start = 1'b0;
        #12;
        n_checks++; if (busy !== 1'b0)  begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (hi !== 32'd0)   begin n_fail++; $display("FAIL reset_hi: got %h want 0", hi); end
        n_checks++; if (lo !== 32'd0)   begin n_fail++; $display("FAIL reset_lo: got %h want 0", lo); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult;
        int c; logic [31:0] mh, ml;
        run_op(3'd1, 32'hFFFF_FFFE, 32'd3, c, mh, ml);
        n_checks++; if (c !== 5) begin n_fail++; $display("FAIL mult_busy_cycles: got %0d want 5", c); end
        n_checks++; if (ml !== 32'd0) begin n_fail++; $display("FAIL mult_lo_during_run: got %h want 0", ml); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFA) begin n_fail++; $display("FAIL mult_lo: got %h want fffffffa", lo); end
    endtask

    task automatic test_multu;
        int c; logic [31:0] mh, ml;
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, c, mh, ml);
        n_checks++; if (c !== 5) begin n_fail++; $display("FAIL multu_busy_cycles: got %0d want 5", c); end
        n_checks++; if (mh !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL multu_hi_during_run: got %h want ffffffff", mh); end
        n_checks++; if (hi !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_hi: got %h want 00000001", hi); end
        n_checks++; if (lo !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
    endtask

    task automatic test_div;
        int c; logic [31:0] mh, ml;
        run_op(3'd3, 32'hFFFF_FFF9, 32'd2, c, mh, ml);
        n_checks++; if (c !== 10) begin n_fail++; $display("FAIL div_busy_cycles: got %0d want 10", c); end
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_lo: got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL div_hi: got %h want ffffffff", hi); end

        run_op(3'd4, 32'd7, 32'd0, c, mh, ml);
        n_checks++; if (c !== 10) begin n_fail++; $display("FAIL divu_zero_busy_cycles: got %0d want 10", c); end
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL divu_zero_lo: got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_zero_hi: got %h want ffffffff", hi); end

        run_op(3'd4, 32'd100, 32'd7, c, mh, ml);
        n_checks++; if (lo !== 32'd14) begin n_fail++; $display("FAIL divu_lo: got %h want 0000000e", lo); end
        n_checks++; if (hi !== 32'd2)  begin n_fail++; $display("FAIL divu_hi: got %h want 00000002", hi); end

        run_op(3'd3, 32'd7, 32'hFFFF_FFFE, c, mh, ml);
        n_checks++; if (lo !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_negdivisor_lo: got %h want fffffffd", lo); end
        n_checks++; if (hi !== 32'd1) begin n_fail++; $display("FAIL div_negdivisor_hi: got %h want 00000001", hi); end

        run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, c, mh, ml);
        n_checks++; if (lo !== 32'h8000_0000) begin n_fail++; $display("FAIL div_overflow_lo: got %h want 80000000", lo); end
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL div_overflow_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_mt_and_ignore;
        int c;
        @(negedge clk);
        op = 3'd6; A = 32'h1234_5678; start = 1'b0;
        @(posedge clk); #1;
        op = 3'd0;
        n_checks++; if (lo !== 32'h1234_5678) begin n_fail++; $display("FAIL mtlo_lo: got %h want 12345678", lo); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mtlo_busy: got %b want 0", busy); end

        // MULT 3*4, then MTHI and a second MULT start while busy: both must be dropped.
        @(negedge clk);
        op = 3'd1; A = 32'd3; B = 32'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd5; A = 32'hDEAD_BEEF;
        c = busy ? 1 : 0;
        @(posedge clk); #1;
        if (busy) c++;
        op = 3'd1; A = 32'd5; B = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        if (busy) c++;
        op = 3'd0; start = 1'b0;
        n_checks++; if (hi !== 32'd0) begin n_fail++; $display("FAIL mthi_while_busy_hi: got %h want 00000000", hi); end
        while (busy && c < 50) begin
            @(posedge clk); #1;
            if (busy) c++;
        end
        n_checks++; if (c !== 5) begin n_fail++; $display("FAIL ignored_start_busy_cycles: got %0d want 5", c); end
        n_checks++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL ignored_start_hi: got %h want 00000000", hi); end
        n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL ignored_start_lo: got %h want 0000000c", lo); end
    endtask

    task automatic test_no_start;
        @(negedge clk);
        op = 3'd1; A = 32'd9; B = 32'd9; start = 1'b0;
        @(posedge clk); #1;
        op = 3'd7; A = 32'hFFFF_FFFF; start = 1'b1;
        @(posedge clk); #1;
        op = 3'd0; start = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL nostart_busy: got %b want 0", busy); end
        n_checks++; if (lo !== 32'd12) begin n_fail++; $display("FAIL nostart_lo: got %h want 0000000c", lo); end
        n_checks++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL nostart_hi: got %h want 00000000", hi); end
    endtask

    task automatic test_reset_mid_run;
        int c; logic [31:0] mh, ml;
        @(negedge clk);
        op = 3'd5; A = 32'hCAFE_F00D;
        @(negedge clk);
        op = 3'd3; A = 32'd100; B = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        op = 3'd0; start = 1'b0;
        repeat (6) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_checks++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL midreset_hi: got %h want 00000000", hi); end
        n_checks++; if (lo !== 32'd0)  begin n_fail++; $display("FAIL midreset_lo: got %h want 00000000", lo); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        op = 3'd1; A = 32'd7; B = 32'd6; start = 1'b1;
        @(posedge clk); #1;
        op = 3'd0; start = 1'b0;
        c = 0;
        while (busy && c < 50) begin
            c++;
            @(posedge clk); #1;
        end
        n_checks++; if (c !== 5)       begin n_fail++; $display("FAIL post_reset_mult_cycles: got %0d want 5", c); end
        n_checks++; if (lo !== 32'd42) begin n_fail++; $display("FAIL post_reset_mult_lo: got %h want 0000002a", lo); end
        n_checks++; if (hi !== 32'd0)  begin n_fail++; $display("FAIL post_reset_mult_hi: got %h want 00000000", hi); end
        repeat (12) @(posedge clk);
        #1;
        n_checks++; if (lo !== 32'd42 || hi !== 32'd0) begin
            n_fail++; $display("FAIL aborted_div_landed: got hi=%h lo=%h want hi=00000000 lo=0000002a", hi, lo);
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_multu();
        test_div();
        test_mt_and_ignore();
        test_no_start();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mdu.md
MDU -- requirements
Module: mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5: number of cycles busy stays high for MULT/MULTU.
REQ-002 Parameter DIV_CYCLES, default 10: number of cycles busy stays high for DIV/DIVU.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset; clears all state when low.
REQ-005 A  input  32  E-stage rs operand, after forwarding.
REQ-006 B  input  32  E-stage rt operand, after forwarding.
REQ-007 op  input  3  operation: 0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO; 7 is treated as NONE.
REQ-008 start  input  1  one-cycle qualifier; op 1-4 are launched only when start=1.
REQ-009 busy  output  1  a multiply or divide is in flight.
REQ-010 hi  output  32  current architectural HI register.
REQ-011 lo  output  32  current architectural LO register.

Function
REQ-012 Internal state: HI, LO, a result buffer (rhi, rlo), and a down-counter cnt wide enough for max(MULT_CYCLES, DIV_CYCLES).
REQ-013 FSM states: IDLE (cnt=0, busy=0) and RUN (cnt>0, busy=1); busy is a registered decode of cnt!=0, with no combinational path from inputs.
REQ-014 IDLE->RUN: on the edge where start=1, op in {1..4} and busy=0.
- Compute the result from the A/B values sampled on that edge into rhi/rlo.
- Load cnt with MULT_CYCLES or DIV_CYCLES.
REQ-015 RUN: decrement cnt on each edge; on the edge where cnt goes 1->0, copy rhi->HI and rlo->LO and return to IDLE.
REQ-016 Latency: start sampled at edge E0 -> busy high for exactly N cycles after E0 -> HI/LO hold the new value starting at edge E0+N, with N = MULT_CYCLES or DIV_CYCLES.
REQ-017 While busy=1, start and all op values are ignored; the MDU neither restarts nor queues.
- The stall controller stalls D on (start | busy) whenever the D instruction uses the MDU.
REQ-018 MULT: {HI,LO} = signed A × signed B as a 64-bit product.
REQ-019 MULTU: {HI,LO} = unsigned A × unsigned B as a 64-bit product.
REQ-020 DIV: LO = signed A / B, truncated toward zero; HI = remainder, carrying the sign of A.
REQ-021 DIVU: LO = unsigned quotient; HI = unsigned remainder.
REQ-022 Division by zero (B=0) for DIV/DIVU: the full DIV_CYCLES busy period still occurs, and HI/LO keep their prior values.
REQ-023 DIV overflow (A=0x80000000, B=0xFFFFFFFF): LO=0x80000000 and HI=0.
REQ-024 MTHI: when busy=0, HI<=A on the edge; no busy period; start is not required.
REQ-025 MTLO: when busy=0, LO<=A on the edge; no busy period; start is not required.
REQ-026 MTHI/MTLO presented while busy=1 are ignored.
REQ-027 hi and lo are direct register outputs; MFHI/MFLO selection is done in the datapath, not in this block.
REQ-028 Reads during RUN return the old HI/LO; the pipeline never observes partial results.
REQ-029 op=NONE, or op 1-4 with start=0: no state change.

Reset
REQ-030 While reset=0, asynchronously force HI=0, LO=0, rhi=0, rlo=0, cnt=0 and busy=0.
REQ-031 Reset asserted mid-RUN aborts the operation; HI/LO read 0 after reset and are never written by the aborted result.
REQ-032 Deassertion is sampled at the next rising edge; a start on that first edge is accepted normally.

Verification
REQ-033 MULT: A=0xFFFFFFFE (-2), B=3, start pulse -> busy=1 for exactly 5 cycles; then HI=0xFFFFFFFF and LO=0xFFFFFFFA.
REQ-034 MULTU: A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001 and LO=0xFFFFFFFE.
REQ-035 DIV: A=-7 (0xFFFFFFF9), B=2 -> busy for 10 cycles; LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1).
- Then DIVU with A=7, B=0 -> busy for 10 cycles; HI/LO are unchanged.
REQ-036 MTLO A=0x12345678 at idle -> LO=0x12345678 after one edge with busy=0.
- Then MULT start followed by MTHI while busy -> HI is not written by the MTHI.
- A second start asserted during busy -> ignored, and busy drops at the first operation's count.
REQ-037 DIV started, then reset=0 asserted mid-cycle at busy count 4 -> busy, HI and LO go to 0 immediately without waiting for clk.
- Completion never lands.
- A MULT 7×6 started on the first edge after release -> LO=42 after 5 cycles.
